icache_controller: RTL and testbench

- Direct-mapped, read-only instruction cache between the PC register and main instruction memory.
- Hit: instruction returned combinationally in the same cycle, so the single-cycle core does not stall.
- Miss: the core is stalled while a line-refill FSM fetches the whole line word by word over a valid-handshake memory port.
- Software-visible flush and hit/miss counters support bring-up and performance measurement.

---
 rtl/icache_pkg.sv | 37 +++
 rtl/icache_line_store.sv | 54 +++++
 rtl/icache_controller.sv | 140 ++++++++++++++
 tb/tb_icache_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, default geometry and address-field helpers for the instruction cache
package icache_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_LINES          = 16;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_CNT_W          = 32;

    localparam int OFS = $clog2(DEF_WORDS_PER_LINE);
    localparam int IDX = $clog2(DEF_LINES);
    localparam int TAG = DEF_ADDR_W - 2 - OFS - IDX;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_UPDATE
    } state_t;

    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

    // Field layout from the LSB: 2 byte bits, word offset, line index, tag.
    function automatic logic [63:0] word_ofs(input logic [63:0] addr, input int ofs_w);
        return addr_field(addr, 2, ofs_w);
    endfunction

    function automatic logic [63:0] line_idx(input logic [63:0] addr, input int ofs_w, input int idx_w);
        return addr_field(addr, 2 + ofs_w, idx_w);
    endfunction

    function automatic logic [63:0] line_tag(input logic [63:0] addr, input int ofs_w, input int idx_w,
                                             input int tag_w);
        return addr_field(addr, 2 + ofs_w + idx_w, tag_w);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - tag, data and valid arrays of the direct-mapped instruction cache
module icache_line_store #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24,
    parameter int IDX_W          = $clog2(LINES),
    parameter int OFS_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFS_W-1:0] rd_ofs,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFS_W-1:0] wr_ofs,
    input  logic [31:0]      wr_data,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             flush
);

    logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_data  = data_mem[{rd_idx, rd_ofs}];

    // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_idx, wr_ofs}] <= wr_data;
        end
        if (set_en) begin
            tag_mem[set_idx] <= set_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (set_en) begin
            valid[set_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - direct-mapped read-only instruction cache with line-refill FSM and hit/miss counters
module icache_controller
    import icache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_aresetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       o_rdata,
    output logic              o_hit,
    output logic              o_stall,
    input  logic              i_flush,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_valid,
    input  logic [31:0]       i_mem_rdata,
    output logic [CNT_W-1:0]  o_hit_count,
    output logic [CNT_W-1:0]  o_miss_count
);

    localparam int OFS_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - OFS_W - IDX_W;
    localparam logic [OFS_W-1:0] LAST_WORD = OFS_W'(WORDS_PER_LINE - 1);

    state_t             state;
    logic [OFS_W-1:0]   word_cnt;
    logic [TAG_W-1:0]   fill_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic               flush_pending;
    logic [CNT_W-1:0]   hit_count;
    logic [CNT_W-1:0]   miss_count;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFS_W-1:0]   req_ofs;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic [31:0]        rd_data;
    logic               lookup_hit;
    logic               fill_word;
    logic               fill_last;
    logic               store_set;
    logic               store_flush;

    assign req_ofs = OFS_W'(word_ofs(64'(i_addr), OFS_W));
    assign req_idx = IDX_W'(line_idx(64'(i_addr), OFS_W, IDX_W));
    assign req_tag = TAG_W'(line_tag(64'(i_addr), OFS_W, IDX_W, TAG_W));

    assign lookup_hit = (state == ST_IDLE) && i_req && rd_valid && (rd_tag == req_tag);
    assign fill_word  = (state == ST_REFILL) && i_mem_valid;
    assign fill_last  = fill_word && (word_cnt == LAST_WORD);
    // A flush seen at any point of the refill keeps the new line invalid.
    assign store_set  = fill_last && !flush_pending && !i_flush;
    assign store_flush = ((state == ST_IDLE) && i_flush) ||
                         ((state == ST_UPDATE) && (flush_pending || i_flush));

    icache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W),
        .IDX_W          (IDX_W),
        .OFS_W          (OFS_W)
    ) u_store (
        .clk      (i_clk),
        .rst_n    (i_aresetn),
        .rd_idx   (req_idx),
        .rd_ofs   (req_ofs),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_en    (fill_word),
        .wr_idx   (fill_idx),
        .wr_ofs   (word_cnt),
        .wr_data  (i_mem_rdata),
        .set_en   (store_set),
        .set_idx  (fill_idx),
        .set_tag  (fill_tag),
        .flush    (store_flush)
    );

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state         <= ST_IDLE;
            word_cnt      <= '0;
            fill_tag      <= '0;
            fill_idx      <= '0;
            flush_pending <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            if (lookup_hit && (hit_count != '1)) begin
                hit_count <= hit_count + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (i_req && !lookup_hit) begin
                        fill_tag <= req_tag;
                        fill_idx <= req_idx;
                        word_cnt <= '0;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                        state <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (i_flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (i_mem_valid) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    flush_pending <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_hit        = lookup_hit;
    assign o_rdata      = rd_data;
    assign o_stall      = (state != ST_IDLE) || (i_req && !lookup_hit);
    assign o_mem_req    = (state == ST_REFILL);
    assign o_mem_addr   = {fill_tag, fill_idx, word_cnt, 2'b00};
    assign o_hit_count  = hit_count;
    assign o_miss_count = miss_count;

endmodule

// File: tb/tb_icache_controller.sv
// tb/tb_icache_controller.sv - self-checking bench for icache_controller against a line-level cache model
module tb_icache_controller;

    localparam int LINES = 16;
    localparam int WPL   = 4;
    localparam int CNT_W = 8;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_aresetn;
    logic              i_req;
    logic [31:0]       i_addr;
    logic [31:0]       o_rdata;
    logic              o_hit;
    logic              o_stall;
    logic              i_flush;
    logic              o_mem_req;
    logic [31:0]       o_mem_addr;
    logic              i_mem_valid;
    logic [31:0]       i_mem_rdata;
    logic [CNT_W-1:0]  o_hit_count;
    logic [CNT_W-1:0]  o_miss_count;

    always #5 i_clk = ~i_clk;

    icache_controller #(
        .ADDR_W         (32),
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL),
        .CNT_W          (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_aresetn    (i_aresetn),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .o_rdata      (o_rdata),
        .o_hit        (o_hit),
        .o_stall      (o_stall),
        .i_flush      (i_flush),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_valid  (i_mem_valid),
        .i_mem_rdata  (i_mem_rdata),
        .o_hit_count  (o_hit_count),
        .o_miss_count (o_miss_count)
    );

    int checks   = 0;
    int failures = 0;

    // Cache model: which line number (addr >> 4) each index holds, plus the outstanding refill.
    bit          m_valid [LINES];
    logic [27:0] m_line  [LINES];
    logic [27:0] fill_line;
    int          words_left = 0;
    bit          in_update  = 0;
    bit          pend       = 0;
    int unsigned m_hits     = 0;
    int unsigned m_misses   = 0;

    int          wait_left = -1;
    int          wait_mode = 0;
    logic        last_obs_hit;
    logic [31:0] acc_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h4) return 32'hA0 + 32'(a[3:2]);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        words_left = 0;
        in_update  = 0;
        pend       = 0;
        m_hits     = 0;
        m_misses   = 0;
        wait_left  = -1;
    endtask

    // Memory answers after wait_mode idle cycles (random 0..3 when negative) and toggles valid randomly when idle.
    task automatic drive_mem();
        if (o_mem_req) begin
            if (wait_left < 0) wait_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
            if (wait_left == 0) begin
                i_mem_valid = 1'b1;
                i_mem_rdata = mem_word(o_mem_addr);
                wait_left   = -1;
            end else begin
                i_mem_valid = 1'b0;
                i_mem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            wait_left   = -1;
            i_mem_valid = 1'($urandom_range(0, 1));
            i_mem_rdata = $urandom;
        end
    endtask

    task automatic cycle(input logic req, input logic [31:0] a, input logic flush);
        logic        exp_hit;
        logic        busy;
        logic [27:0] ln;
        int          idx;
        i_req   = req;
        i_addr  = a;
        i_flush = flush;
        drive_mem();
        #1;
        ln   = a[31:4];
        idx  = int'(a[7:4]);
        busy = (words_left > 0) || in_update;
        exp_hit = req && !busy && m_valid[idx] && (m_line[idx] == ln);
        chk("hit", 32'(o_hit), 32'(exp_hit));
        if (exp_hit) chk("rdata", o_rdata, mem_word({a[31:2], 2'b00}));
        chk("stall", 32'(o_stall), 32'(busy || (req && !exp_hit)));
        chk("mem_req", 32'(o_mem_req), 32'(words_left > 0));
        if (words_left > 0) chk("mem_addr", o_mem_addr, {fill_line, 4'b0} + 32'(4 * (WPL - words_left)));
        chk("hit_count", 32'(o_hit_count), m_hits);
        chk("miss_count", 32'(o_miss_count), m_misses);
        last_obs_hit = o_hit;
        if (o_mem_req && i_mem_valid) acc_q.push_back(o_mem_addr);

        if (exp_hit && m_hits < CMAX) m_hits++;
        if (flush && busy) pend = 1;
        if (!busy) begin
            if (flush) model_clear();
            if (req && !exp_hit) begin
                if (m_misses < CMAX) m_misses++;
                fill_line  = ln;
                words_left = WPL;
            end
        end else if (words_left > 0) begin
            if (i_mem_valid) begin
                words_left--;
                if (words_left == 0) begin
                    in_update = 1;
                    if (!pend) begin
                        m_valid[int'(fill_line[3:0])] = 1'b1;
                        m_line[int'(fill_line[3:0])]  = fill_line;
                    end
                end
            end
        end else begin
            in_update = 0;
            if (pend) model_clear();
            pend = 0;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_until_hit(input logic [31:0] a);
        int n = 0;
        do begin
            cycle(1'b1, a, 1'b0);
            n++;
        end while (!last_obs_hit && n < 80);
        chk("hit_reached", 32'(last_obs_hit), 32'd1);
    endtask

    initial begin
        int n;
        i_aresetn   = 1'b0;
        i_req       = 1'b0;
        i_addr      = '0;
        i_flush     = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_rdata = '0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_hit", 32'(o_hit), 32'd0);
        chk("rst_hit_count", 32'(o_hit_count), 32'd0);
        chk("rst_miss_count", 32'(o_miss_count), 32'd0);
        i_aresetn = 1'b1;

        // Cold miss with one wait cycle per word.
        wait_mode = 1;
        acc_q.delete();
        run_until_hit(32'h40);
        chk("cold_words", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("cold_addr", acc_q[i], 32'h40 + 32'(4 * i));
        chk("cold_miss_count", 32'(o_miss_count), 32'd1);
        chk("cold_rdata", o_rdata, 32'hA0);

        // Spatial hits on the rest of the line.
        cycle(1'b1, 32'h44, 1'b0);
        cycle(1'b1, 32'h48, 1'b0);
        cycle(1'b1, 32'h4C, 1'b0);
        chk("spatial_hit_count", 32'(o_hit_count), 32'd4);

        // Conflict eviction on index 4.
        run_until_hit(32'h440);
        run_until_hit(32'h40);
        chk("conflict_miss_count", 32'(o_miss_count), 32'd3);

        // Flush on the second word of a refill.
        wait_mode = 0;
        acc_q.delete();
        cycle(1'b1, 32'h80, 1'b0);
        cycle(1'b1, 32'h80, 1'b0);
        cycle(1'b1, 32'h80, 1'b1);
        n = 0;
        while (((words_left > 0) || in_update) && n < 40) begin
            cycle(1'b1, 32'h80, 1'b0);
            n++;
        end
        chk("flush_refill_words", 32'(acc_q.size()), 32'd4);
        cycle(1'b1, 32'h80, 1'b0);
        chk("flush_refetch_hit", 32'(last_obs_hit), 32'd0);
        run_until_hit(32'h80);
        cycle(1'b1, 32'h440, 1'b0);
        chk("flush_old_line_hit", 32'(last_obs_hit), 32'd0);
        n = 0;
        while (((words_left > 0) || in_update) && n < 40) begin
            cycle(1'b0, 32'h0, 1'b0);
            n++;
        end

        // Asynchronous reset after word 2 of a refill.
        cycle(1'b1, 32'h100, 1'b0);
        cycle(1'b1, 32'h100, 1'b0);
        cycle(1'b1, 32'h100, 1'b0);
        i_aresetn = 1'b0;
        i_req     = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(o_mem_req), 32'd0);
        chk("midrst_stall", 32'(o_stall), 32'd0);
        chk("midrst_hit_count", 32'(o_hit_count), 32'd0);
        chk("midrst_miss_count", 32'(o_miss_count), 32'd0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_aresetn = 1'b1;
        cycle(1'b1, 32'h100, 1'b0);
        chk("midrst_refetch_miss", 32'(last_obs_hit), 32'd0);
        run_until_hit(32'h100);

        // Back-pressure: five idle cycles before each word.
        wait_mode = 5;
        run_until_hit(32'h200);

        // Randomized traffic with occasional flushes.
        wait_mode = -1;
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
                  (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3)),
                  1'($urandom_range(0, 24) == 0));
        end

        // Hit counter saturation from a clean reset.
        i_req     = 1'b0;
        i_aresetn = 1'b0;
        #1;
        model_reset();
        @(posedge i_clk);
        #1;
        i_aresetn = 1'b1;
        wait_mode = 0;
        run_until_hit(32'h40);
        n = 0;
        while (m_hits < CMAX - 1 && n < 400) begin
            cycle(1'b1, 32'h44, 1'b0);
            n++;
        end
        chk("sat_near_max", 32'(o_hit_count), CMAX - 1);
        repeat (3) cycle(1'b1, 32'h48, 1'b0);
        chk("sat_hit_count", 32'(o_hit_count), CMAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
